vayu_ctrl_seq: RTL and testbench

- Multi-cycle control sequencer for the Vayu core.
- Fetches one instruction at a time from instruction memory over a req/ack handshake and latches it.
- Presents the latched word with a one-cycle valid strobe to the instruction decoder.
- Then sequences one ALU-execute cycle and one register-file writeback cycle, using the decoder's reg_write, before advancing the PC.

---
 rtl/vayu_ctrl_seq.sv | 106 ++++++++++
 tb/tb_vayu_ctrl_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/vayu_ctrl_seq.sv
// vayu_ctrl_seq: multi-cycle fetch/decode/execute/writeback control sequencer for the Vayu core.
// Define VAYU_SEQ_PERF_CNT_EN to add retired-instruction and stall-cycle counters.
module vayu_ctrl_seq #(
    parameter logic [31:0] PC_RESET     = 32'h0000_0000,
    parameter logic [31:0] PC_STEP      = 32'd4,
    parameter int unsigned IMEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ip_run,
    input  logic        ip_imem_ack,
    input  logic [31:0] ip_imem_rdata,
    input  logic        ip_reg_write,
    input  logic        ip_stall,
    output logic        op_imem_req,
    output logic [31:0] op_imem_addr,
    output logic [31:0] op_pc,
    output logic [31:0] op_instr,
    output logic        op_instr_valid,
    output logic        op_alu_en,
    output logic        op_rf_we,
    output logic        op_busy,
`ifdef VAYU_SEQ_PERF_CNT_EN
    output logic [31:0] op_retired_cnt,
    output logic [31:0] op_stall_cnt,
`endif
    output logic        op_fault
);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK, S_FAULT} state_t;
    localparam logic [7:0] TO_LAST = 8'(IMEM_TIMEOUT - 1);

    state_t      r_state, w_next;
    logic [7:0]  r_cnt;
    logic [31:0] r_pc, r_instr;
    logic        w_ack;

    assign w_ack        = r_state == S_FETCH && ip_imem_ack;
    assign op_pc        = r_pc;
    assign op_imem_addr = r_pc;
    assign op_instr     = r_instr;

    always_ff @(posedge clk or posedge rst)
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;

    always_comb begin
        w_next         = r_state;
        op_imem_req    = 1'b0;
        op_instr_valid = 1'b0;
        op_alu_en      = 1'b0;
        op_rf_we       = 1'b0;
        op_fault       = 1'b0;
        op_busy        = r_state != S_IDLE && r_state != S_FAULT;
        case (r_state)
            S_IDLE:      w_next = ip_run ? S_FETCH : S_IDLE;
            // an ack arriving on the last allowed cycle still wins over the timeout
            S_FETCH: begin
                op_imem_req = 1'b1;
                w_next      = ip_imem_ack ? S_DECODE : (r_cnt == TO_LAST ? S_FAULT : S_FETCH);
            end
            S_DECODE: begin
                op_instr_valid = 1'b1;
                w_next         = S_EXECUTE;
            end
            S_EXECUTE: begin
                op_alu_en = 1'b1;
                w_next    = ip_stall ? S_EXECUTE : S_WRITEBACK;
            end
            S_WRITEBACK: begin
                op_rf_we = ip_reg_write;
                w_next   = ip_run ? S_FETCH : S_IDLE;
            end
            S_FAULT:     op_fault = 1'b1;
            default:     w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_pc    <= PC_RESET;
            r_instr <= '0;
            r_cnt   <= '0;
        end else begin
            if (w_ack) begin
                r_instr <= ip_imem_rdata;
                r_cnt   <= '0;
            end else if (r_state == S_FETCH) r_cnt <= r_cnt + 8'd1;
            if (r_state == S_WRITEBACK) r_pc <= r_pc + PC_STEP;
        end

`ifdef VAYU_SEQ_PERF_CNT_EN
    logic [31:0] r_ret, r_stl;

    assign op_retired_cnt = r_ret;
    assign op_stall_cnt   = r_stl;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_ret <= '0;
            r_stl <= '0;
        end else begin
            if (r_state == S_WRITEBACK) r_ret <= r_ret + 32'd1;
            if ((r_state == S_EXECUTE && ip_stall) || (r_state == S_FETCH && !ip_imem_ack)) r_stl <= r_stl + 32'd1;
        end
`endif
endmodule

// File: tb/tb_vayu_ctrl_seq.sv
// tb_vayu_ctrl_seq: directed scenarios expanded into a per-cycle expected trace, checked every cycle.
// Two instances share stimulus; the second starts at PC 0xFFFF_FFFC to exercise wrap-around.
module tb_vayu_ctrl_seq;
    localparam int TO = 15;
    localparam logic [31:0] PC1 = 32'hFFFF_FFFC;

    logic clk = 1'b0, rst = 1'b1;
    logic run = 1'b0, ack = 1'b0, stall = 1'b0, rw = 1'b0;
    logic [31:0] rdata = '0;
    logic req0, valid0, alu0, we0, busy0, fault0, req1, valid1, alu1, we1, busy1, fault1;
    logic [31:0] addr0, pc0, instr0, addr1, pc1, instr1;
`ifdef VAYU_SEQ_PERF_CNT_EN
    logic [31:0] ret0, stl0, ret1, stl1;
`endif

    always #5 clk = ~clk;

    vayu_ctrl_seq u0 (
        .clk(clk), .rst(rst), .ip_run(run), .ip_imem_ack(ack), .ip_imem_rdata(rdata),
        .ip_reg_write(rw), .ip_stall(stall), .op_imem_req(req0), .op_imem_addr(addr0),
        .op_pc(pc0), .op_instr(instr0), .op_instr_valid(valid0), .op_alu_en(alu0),
        .op_rf_we(we0), .op_busy(busy0),
`ifdef VAYU_SEQ_PERF_CNT_EN
        .op_retired_cnt(ret0), .op_stall_cnt(stl0),
`endif
        .op_fault(fault0)
    );

    vayu_ctrl_seq #(.PC_RESET(PC1)) u1 (
        .clk(clk), .rst(rst), .ip_run(run), .ip_imem_ack(ack), .ip_imem_rdata(rdata),
        .ip_reg_write(rw), .ip_stall(stall), .op_imem_req(req1), .op_imem_addr(addr1),
        .op_pc(pc1), .op_instr(instr1), .op_instr_valid(valid1), .op_alu_en(alu1),
        .op_rf_we(we1), .op_busy(busy1),
`ifdef VAYU_SEQ_PERF_CNT_EN
        .op_retired_cnt(ret1), .op_stall_cnt(stl1),
`endif
        .op_fault(fault1)
    );

    int n_pass = 0, n_tot = 0, n = 0, cyc = 0;
    bit chk_on = 1'b0;

    logic        e_req[0:127], e_valid[0:127], e_alu[0:127], e_we[0:127], e_busy[0:127], e_fault[0:127];
    logic [31:0] e_pc[0:127], e_instr[0:127];
    logic        s_run[0:127], s_ack[0:127], s_stall[0:127], s_rw[0:127];
    logic [31:0] s_rd[0:127];
    logic        a_req[0:127], a_valid[0:127], a_alu[0:127], a_we[0:127], a_busy[0:127], a_fault[0:127];
    logic [31:0] a_addr[0:127], a_pc[0:127], a_instr[0:127], a_addr1[0:127];
    logic [31:0] m_pc = 32'h0, m_instr = 32'h0;
`ifdef VAYU_SEQ_PERF_CNT_EN
    logic [31:0] e_ret[0:127], e_stl[0:127];
    logic [31:0] m_ret = 32'h0, m_stl = 32'h0;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // one cycle of the expected trace: outputs from the rules, plus the inputs to drive
    task automatic emit(input logic rq, vl, al, wb, bs, ft, rn, ak, st, w, input logic [31:0] rd);
        e_req[n] = rq; e_valid[n] = vl; e_alu[n] = al; e_we[n] = wb & w; e_busy[n] = bs; e_fault[n] = ft;
        e_pc[n] = m_pc; e_instr[n] = m_instr;
`ifdef VAYU_SEQ_PERF_CNT_EN
        e_ret[n] = m_ret; e_stl[n] = m_stl;
`endif
        s_run[n] = rn; s_ack[n] = ak; s_stall[n] = st; s_rw[n] = w; s_rd[n] = rd;
        n++;
    endtask

    task automatic idle(input int k, input logic rn);
        for (int i = 0; i < k; i++) emit(0, 0, 0, 0, 0, 0, rn, 0, 0, 0, 32'h0);
    endtask

    // one instruction: ack after d wait cycles, s stalled execute cycles, run level in writeback
    task automatic instr(input int d, input int s, input logic w, input logic nxt, input logic [31:0] word);
        for (int i = 0; i <= d; i++) begin
            emit(1, 0, 0, 0, 1, 0, 0, i == d, 0, 0, i == d ? word : 32'hBAD0_0000 | 32'(i));
`ifdef VAYU_SEQ_PERF_CNT_EN
            if (i < d) m_stl++;
`endif
        end
        m_instr = word;
        emit(0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 32'hDEAD_BEEF);
        for (int i = 0; i <= s; i++) begin
            emit(0, 0, 1, 0, 1, 0, 0, 1, i < s, 0, 32'hDEAD_BEEF);
`ifdef VAYU_SEQ_PERF_CNT_EN
            if (i < s) m_stl++;
`endif
        end
        emit(0, 0, 0, 1, 1, 0, nxt, 0, 0, w, 32'h0);
        m_pc += 32'd4;
`ifdef VAYU_SEQ_PERF_CNT_EN
        m_ret++;
`endif
    endtask

    task automatic fault_run(input int k);
        for (int i = 0; i < TO; i++) begin
            emit(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 32'h0);
`ifdef VAYU_SEQ_PERF_CNT_EN
            m_stl++;
`endif
        end
        for (int i = 0; i < k; i++) emit(0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 32'h1234_5678);
    endtask

    always @(negedge clk) if (chk_on) begin
        chk($sformatf("req@%0d", cyc), 32'(req0), 32'(e_req[cyc]));
        chk($sformatf("addr@%0d", cyc), addr0, e_pc[cyc]);
        chk($sformatf("pc@%0d", cyc), pc0, e_pc[cyc]);
        chk($sformatf("instr@%0d", cyc), instr0, e_instr[cyc]);
        chk($sformatf("valid@%0d", cyc), 32'(valid0), 32'(e_valid[cyc]));
        chk($sformatf("alu@%0d", cyc), 32'(alu0), 32'(e_alu[cyc]));
        chk($sformatf("we@%0d", cyc), 32'(we0), 32'(e_we[cyc]));
        chk($sformatf("busy@%0d", cyc), 32'(busy0), 32'(e_busy[cyc]));
        chk($sformatf("fault@%0d", cyc), 32'(fault0), 32'(e_fault[cyc]));
        chk($sformatf("u1_pc@%0d", cyc), pc1, e_pc[cyc] + PC1);
        chk($sformatf("u1_addr@%0d", cyc), addr1, e_pc[cyc] + PC1);
        chk($sformatf("u1_strobes@%0d", cyc), {26'h0, req1, valid1, alu1, we1, busy1, fault1},
            {26'h0, e_req[cyc], e_valid[cyc], e_alu[cyc], e_we[cyc], e_busy[cyc], e_fault[cyc]});
        chk($sformatf("u1_instr@%0d", cyc), instr1, e_instr[cyc]);
`ifdef VAYU_SEQ_PERF_CNT_EN
        chk($sformatf("ret@%0d", cyc), ret0, e_ret[cyc]);
        chk($sformatf("stl@%0d", cyc), stl0, e_stl[cyc]);
        chk($sformatf("u1_ret@%0d", cyc), ret1, e_ret[cyc]);
        chk($sformatf("u1_stl@%0d", cyc), stl1, e_stl[cyc]);
`endif
        a_req[cyc] = req0; a_valid[cyc] = valid0; a_alu[cyc] = alu0; a_we[cyc] = we0;
        a_busy[cyc] = busy0; a_fault[cyc] = fault0; a_addr[cyc] = addr0; a_pc[cyc] = pc0;
        a_instr[cyc] = instr0; a_addr1[cyc] = addr1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        idle(2, 0); idle(1, 1);
        instr(0, 0, 1, 1, 32'h0000_0013);
        instr(0, 0, 1, 1, 32'h0010_0093);
        instr(0, 0, 1, 0, 32'h0020_0113);
        idle(1, 0); idle(1, 1); instr(3, 0, 1, 0, 32'hA5A5_0001);
        idle(1, 0); idle(1, 1); instr(0, 2, 1, 0, 32'h5A5A_0002);
        idle(1, 0); idle(1, 1); instr(0, 0, 0, 0, 32'h1111_2222);
        idle(1, 0); idle(1, 1); instr(TO - 1, 0, 1, 0, 32'hCAFE_F00D);
        idle(1, 0); idle(1, 1); fault_run(3);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_pc", pc0, 32'h0);
        chk("rst_u1_pc", pc1, PC1);
        chk("rst_instr", instr0, 32'h0);
        chk("rst_strobes", {27'h0, req0, valid0, alu0, we0, busy0}, 32'h0);
        chk("rst_fault", 32'(fault0), 32'h0);
`ifdef VAYU_SEQ_PERF_CNT_EN
        chk("rst_cnts", ret0 | stl0, 32'h0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            cyc = k;
            run = s_run[k]; ack = s_ack[k]; stall = s_stall[k]; rw = s_rw[k]; rdata = s_rd[k];
            chk_on = 1'b1;
        end
        @(posedge clk); #1;
        chk_on = 1'b0;

        chk("lit_addr_a", a_addr[3], 32'd0);
        chk("lit_addr_b", a_addr[7], 32'd4);
        chk("lit_addr_c", a_addr[11], 32'd8);
        chk("lit_req_abc", {29'h0, a_req[3], a_req[7], a_req[11]}, 32'h7);
        chk("lit_we_abc", {28'h0, a_we[5], a_we[6], a_we[10], a_we[14]}, 32'h7);
        chk("lit_pc_12", a_pc[15], 32'd12);
        chk("lit_req_held", {27'h0, a_req[17], a_req[18], a_req[19], a_req[20], a_req[21]}, 32'h1E);
        chk("lit_addr_held", a_addr[20], 32'd12);
        chk("lit_valid_after_ack", 32'(a_valid[21]), 32'h1);
        chk("lit_instr_capt", a_instr[21], 32'hA5A5_0001);
        chk("lit_alu_stall", {28'h0, a_alu[28], a_alu[29], a_alu[30], a_we[30]}, 32'hE);
        chk("lit_we_delayed", 32'(a_we[31]), 32'h1);
        chk("lit_we_off", 32'(a_we[37]), 32'h0);
        chk("lit_pc_after_nowrite", a_pc[38], 32'd24);
        chk("lit_ack_on_timeout", 32'(a_valid[55]), 32'h1);
        chk("lit_fault", {29'h0, a_req[74], a_fault[75], a_busy[75]}, 32'h6);
        chk("lit_fault_pc", a_pc[75], 32'd28);
        chk("lit_u1_addr_a", a_addr1[3], 32'hFFFF_FFFC);
        chk("lit_u1_addr_wrap", a_addr1[7], 32'h0);

        #2 rst = 1'b1;
        #1;
        chk("arst_fault", {30'h0, fault0, busy0}, 32'h0);
        chk("arst_pc", pc0, 32'h0);
        chk("arst_u1_pc", pc1, PC1);
`ifdef VAYU_SEQ_PERF_CNT_EN
        chk("arst_cnts", ret1 | stl1, 32'h0);
`endif
        @(posedge clk); #1;
        rst = 1'b0; run = 1'b1; ack = 1'b0;
        @(posedge clk); #1;
        run = 1'b0;
        chk("mid_fetch_req", {31'h0, req0}, 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("mid_fetch_rst", {30'h0, req0, busy0}, 32'h0);
        chk("mid_fetch_pc", pc1, PC1);
        @(posedge clk); #1;
        rst = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
